layer_fm_buffer: RTL and testbench

Parametrised multi-channel feature-map buffer between a convolution layer's output stream and the next layer's input stream. It captures up to CH_NUM frames of FM_WIDTH×FM_HEIGHT pixels from a vsync/href/data stream into on-chip RAM. On request it replays one selected channel as a vsync/href/data stream with programmable horizontal blanking. It is the single-clock, multi-channel generalisation of the layer-1 feature-map store and is reused for every CNN layer.

---
 rtl/layer_fm_buffer_if.sv | 29 ++
 rtl/layer_fm_buffer.sv | 139 +++++++++++++
 tb/tb_layer_fm_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/layer_fm_buffer_if.sv
// layer_fm_buffer_if: capture/replay stream bundle of the feature-map buffer
interface layer_fm_buffer_if #(
    parameter int DATA_W = 16,
    parameter int CW     = 1
);
    logic              fm_wea;
    logic [CW-1:0]     wr_ch;
    logic              pre_vsync;
    logic              pre_href;
    logic [DATA_W-1:0] pre_data;
    logic              start_output;
    logic [CW-1:0]     rd_ch;
    logic              save_fm_acmp;
    logic              busy;
    logic              end_output;
    logic              post_vsync;
    logic              post_href;
    logic [DATA_W-1:0] post_data;

    modport master (
        output fm_wea, wr_ch, pre_vsync, pre_href, pre_data, start_output, rd_ch,
        input  save_fm_acmp, busy, end_output, post_vsync, post_href, post_data
    );

    modport slave (
        input  fm_wea, wr_ch, pre_vsync, pre_href, pre_data, start_output, rd_ch,
        output save_fm_acmp, busy, end_output, post_vsync, post_href, post_data
    );
endinterface

// File: rtl/layer_fm_buffer.sv
// layer_fm_buffer: multi-channel feature-map store with blanked per-channel replay
module layer_fm_buffer #(
    parameter int DATA_W    = 16,
    parameter int FM_WIDTH  = 4,
    parameter int FM_HEIGHT = 4,
    parameter int CH_NUM    = 2,
    parameter int HBLANK    = 16
) (
    input logic               clk,
    input logic               rst_n,
    layer_fm_buffer_if.slave  fm
);
    localparam int CW      = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
    localparam int FM_SIZE = FM_WIDTH * FM_HEIGHT;
    localparam int AW      = $clog2(CH_NUM * FM_SIZE);
    localparam int PW      = $clog2(FM_SIZE + 1);
    localparam int XW      = $clog2(FM_WIDTH);
    localparam int YW      = FM_HEIGHT > 1 ? $clog2(FM_HEIGHT) : 1;
    localparam int BW      = HBLANK > 1 ? $clog2(HBLANK) : 1;

    typedef enum logic [1:0] {IDLE, LINE, BLANK, DONE} state_t;

    logic [DATA_W-1:0] mem [CH_NUM*FM_SIZE];
    logic [DATA_W-1:0] rd_q;

    logic          vs_q, full_q, acmp_q;
    logic [CW-1:0] wch_q;
    logic [PW-1:0] ptr_q;
    logic          vs_rise, full, we, last_wr;
    logic [CW-1:0] wch;
    logic [PW-1:0] ptr;
    logic [AW-1:0] wr_addr, rd_addr;

    state_t        state_q, state_d;
    logic [CW-1:0] rch_q, rch_d;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic [BW-1:0] bk_q, bk_d;
    logic          href_q, vsync_q, end_q;

    // a pixel coinciding with the vsync rising edge already belongs to the new frame
    always_comb begin
        vs_rise = fm.pre_vsync && !vs_q;
        wch     = vs_rise ? fm.wr_ch : wch_q;
        ptr     = vs_rise ? '0 : ptr_q;
        full    = vs_rise ? 1'b0 : full_q;
        we      = fm.pre_href && fm.fm_wea && fm.pre_vsync && !full && (32'(wch) < CH_NUM);
        last_wr = we && (32'(ptr) == FM_SIZE - 1);
        wr_addr = AW'(32'(wch) * FM_SIZE + 32'(ptr));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q   <= 1'b0;
            wch_q  <= '0;
            ptr_q  <= '0;
            full_q <= 1'b0;
            acmp_q <= 1'b0;
        end else begin
            vs_q   <= fm.pre_vsync;
            wch_q  <= wch;
            ptr_q  <= we ? ptr + 1'b1 : ptr;
            full_q <= full || last_wr;
            acmp_q <= last_wr;
        end
    end

    // read-before-write: a same-address collision returns the previous contents
    always_ff @(posedge clk) begin
        if (we && rst_n)
            mem[wr_addr] <= fm.pre_data;
        rd_q <= mem[rd_addr];
    end

    always_comb begin
        state_d = state_q;
        rch_d   = rch_q;
        col_d   = col_q;
        row_d   = row_q;
        bk_d    = bk_q;
        rd_addr = AW'(32'(rch_q) * FM_SIZE + 32'(row_q) * FM_WIDTH + 32'(col_q));
        case (state_q)
            IDLE: if (fm.start_output && 32'(fm.rd_ch) < CH_NUM) begin
                state_d = LINE;
                rch_d   = fm.rd_ch;
                col_d   = '0;
                row_d   = '0;
            end
            LINE: if (32'(col_q) == FM_WIDTH - 1) begin
                col_d = '0;
                if (32'(row_q) == FM_HEIGHT - 1) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    bk_d    = '0;
                    state_d = BLANK;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
            BLANK: if (32'(bk_q) == HBLANK - 1) begin
                bk_d    = '0;
                state_d = LINE;
            end else begin
                bk_d = bk_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rch_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            bk_q    <= '0;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rch_q   <= rch_d;
            col_q   <= col_d;
            row_q   <= row_d;
            bk_q    <= bk_d;
            href_q  <= state_q == LINE;
            vsync_q <= state_q == LINE || state_q == BLANK;
            end_q   <= state_q == DONE;
        end
    end

    assign fm.save_fm_acmp = acmp_q;
    assign fm.busy         = state_q != IDLE;
    assign fm.end_output   = end_q;
    assign fm.post_vsync   = vsync_q;
    assign fm.post_href    = href_q;
    assign fm.post_data    = href_q ? rd_q : '0;
endmodule

// File: tb/tb_layer_fm_buffer.sv
// tb_layer_fm_buffer: directed capture/replay scenarios with a cycle-stamped scoreboard
module tb_layer_fm_buffer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    layer_fm_buffer_if #(.DATA_W(16), .CW(1)) bus ();

    layer_fm_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fm    (bus)
    );

    typedef struct {
        int          c;
        logic [15:0] d;
    } pix_t;

    pix_t        pq[$];
    int          aq[$];
    int          eq[$];
    logic [15:0] model [2][16];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          t_rd = 0;
    bit          active = 0;
    int          t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle();
        pix_t p;
        chk("busy", bus.busy, active && cyc >= t_rd + 1 && cyc <= t_rd + 65);
        chk("post_vsync", bus.post_vsync, active && cyc >= t_rd + 2 && cyc <= t_rd + 65);
        if (bus.post_href) begin
            if (pq.size() == 0) chk("href_unexpected", bus.post_href, 0);
            else begin
                p = pq.pop_front();
                chk("pix_cycle", cyc, p.c);
                chk("pix_data", bus.post_data, p.d);
            end
        end else begin
            chk("data_idle", bus.post_data, 0);
            if (pq.size() > 0 && pq[0].c <= cyc) begin
                chk("pix_missing", bus.post_href, 1);
                void'(pq.pop_front());
            end
        end
        if (bus.save_fm_acmp) begin
            if (aq.size() == 0) chk("acmp_unexpected", bus.save_fm_acmp, 0);
            else chk("acmp_cycle", cyc, aq.pop_front());
        end else if (aq.size() > 0 && aq[0] <= cyc) begin
            chk("acmp_missing", bus.save_fm_acmp, 1);
            void'(aq.pop_front());
        end
        if (bus.end_output) begin
            if (eq.size() == 0) chk("end_unexpected", bus.end_output, 0);
            else chk("end_cycle", cyc, eq.pop_front());
        end else if (eq.size() > 0 && eq[0] <= cyc) begin
            chk("end_missing", bus.end_output, 1);
            void'(eq.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_acmp"}, bus.save_fm_acmp, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_end"}, bus.end_output, 0);
        chk({tag, "_vsync"}, bus.post_vsync, 0);
        chk({tag, "_href"}, bus.post_href, 0);
        chk({tag, "_data"}, bus.post_data, 0);
    endtask

    task automatic write_frame(input int ch, input int n, input logic [15:0] base, input bit alt);
        int cnt;
        cnt = 0;
        bus.wr_ch     = 1'(ch);
        bus.pre_vsync = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            bus.pre_href = 1'b1;
            bus.pre_data = base + 16'(i);
            bus.fm_wea   = !alt || (i % 2 == 0);
            if (bus.fm_wea && cnt < 16) begin
                model[ch][cnt] = bus.pre_data;
                cnt++;
                if (cnt == 16) aq.push_back(cyc + 1);
            end
            tick();
        end
        bus.pre_href  = 1'b0;
        bus.fm_wea    = 1'b0;
        bus.pre_vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic start_rd(input int ch);
        bus.rd_ch        = 1'(ch);
        bus.start_output = 1'b1;
        if (!active || cyc >= t_rd + 66) begin
            t_rd   = cyc;
            active = 1'b1;
            for (int k = 0; k < 16; k++)
                pq.push_back('{c: t_rd + 2 + k % 4 + (k / 4) * 20, d: model[ch][k]});
            eq.push_back(t_rd + 66);
        end
        tick();
        bus.start_output = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.fm_wea       = 1'b0;
        bus.wr_ch        = '0;
        bus.pre_vsync    = 1'b0;
        bus.pre_href     = 1'b0;
        bus.pre_data     = '0;
        bus.start_output = 1'b0;
        bus.rd_ch        = '0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        write_frame(0, 16, 16'h0000, 1'b0);
        write_frame(1, 16, 16'h0100, 1'b0);

        t0 = cyc;
        start_rd(1);
        run_to(t0 + 10);
        start_rd(0);
        run_to(t0 + 40);
        start_rd(0);
        run_to(t0 + 66);
        start_rd(1);
        run_to(t_rd + 70);

        write_frame(0, 20, 16'h0200, 1'b0);
        start_rd(0);
        run_to(t_rd + 70);

        write_frame(1, 32, 16'h0300, 1'b1);
        start_rd(1);
        run_to(t_rd + 70);

        t0 = cyc;
        start_rd(1);
        run_to(t0 + 30);
        rst_n  = 1'b0;
        active = 1'b0;
        pq.delete();
        eq.delete();
        tick();
        check_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        start_rd(1);
        run_to(t_rd + 70);

        chk("pix_left", pq.size(), 0);
        chk("acmp_left", aq.size(), 0);
        chk("end_left", eq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
